// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, drives IF/ID. Optional FETCH_PERF_CNT_EN adds fetch_count_o.
// Latency: request issue to fd_valid_o = memory latency + 1; stall_i holds the delivered word, redirect squashes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcsrc_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count_o,
`endif
  output logic        fd_valid_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic        first_q;
  logic        fd_valid_q;
  logic        accept;
  logic        load;
  logic        consume;
  logic [31:0] redirect_target;

  // Request is suppressed for one cycle after reset release.
  assign imem_req_o      = (state_q == S_REQ) && !first_q;
  assign imem_addr_o     = pc_q;
  assign accept          = imem_req_o && imem_ready_i;
  assign redirect_target = redirect_pc_i & ~32'h3;
  assign fd_valid_o      = fd_valid_q;
  assign consume         = fd_valid_q && !stall_i && !redirect_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      S_REQ: begin
        if (accept) state_d = redirect_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          state_d = S_HOLD;
          load    = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_i || !stall_i) state_d = S_REQ;
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q          <= RESET_PC;
      first_q       <= 1'b1;
      fd_valid_q    <= 1'b0;
      instruction_o <= 32'h0;
      pc_o          <= 32'h0;
      pcsrc_o       <= 32'h0;
    end else begin
      first_q <= 1'b0;
      if (redirect_i) begin
        pc_q       <= redirect_target;
        fd_valid_q <= 1'b0;
      end else if (load) begin
        instruction_o <= imem_rdata_i;
        pc_o          <= pc_q;
        pcsrc_o       <= pc_q + PC_STEP;
        fd_valid_q    <= 1'b1;
        pc_q          <= pc_q + PC_STEP;
      end else if (consume) begin
        fd_valid_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_count_o <= 32'h0;
    end else if (consume) begin
      fetch_count_o <= fetch_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; expected deliveries are queued when a response is driven and popped on fd_valid_o.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] pcsrc_o;
  logic        fd_valid_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_o;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcsrc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_1000), .PC_STEP(32'd4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instruction_o(instruction_o), .pc_o(pc_o), .pcsrc_o(pcsrc_o),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count_o(fetch_count_o),
`endif
    .fd_valid_o(fd_valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check32(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic respond(input logic [31:0] data, input logic expected, input logic [31:0] pc);
    exp_t e;
    if (expected) begin
      e.instr = data; e.pc = pc; e.pcsrc = pc + 32'd4;
      sb.push_back(e);
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
  endtask

  task automatic expect_delivery(input string tag);
    exp_t e;
    for (int i = 0; i < 8 && !fd_valid_o; i++) tick();
    check1({tag, "_vld"}, fd_valid_o, 1'b1);
    if (sb.size() == 0) begin
      check1({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check32({tag, "_instr"}, instruction_o, e.instr);
      check32({tag, "_pc"}, pc_o, e.pc);
      check32({tag, "_pcsrc"}, pcsrc_o, e.pcsrc);
    end
  endtask

  // Accept at the current address, wait one idle cycle, respond, and collect the delivery.
  task automatic fetch_one(input string tag, input logic [31:0] data, input logic [31:0] pc);
    check32({tag, "_addr"}, imem_addr_o, pc);
    check1({tag, "_req"}, imem_req_o, 1'b1);
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    tick();
    respond(data, 1'b1, pc);
    expect_delivery(tag);
  endtask

  initial begin
    reset_i = 1'b0; imem_ready_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    tick(); tick();
    check1("rst_req", imem_req_o, 1'b0);
    check1("rst_vld", fd_valid_o, 1'b0);
    check32("rst_instr", instruction_o, 32'h0);
    check32("rst_pc", pc_o, 32'h0);
    check32("rst_pcsrc", pcsrc_o, 32'h0);
    check32("rst_addr", imem_addr_o, 32'h1000);

    reset_i = 1'b1;
    imem_ready_i = 1'b1;
    check1("first_cycle_noreq", imem_req_o, 1'b0);
    tick();
    check1("req_after_release", imem_req_o, 1'b1);
    check32("req_addr", imem_addr_o, 32'h1000);
    tick();
    imem_ready_i = 1'b0;
    check1("wait_noreq", imem_req_o, 1'b0);
    tick();
    respond(32'h0000_0013, 1'b1, 32'h1000);
    expect_delivery("d0");

    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check1("stall_vld", fd_valid_o, 1'b1);
      check32("stall_instr", instruction_o, 32'h13);
      check32("stall_pc", pc_o, 32'h1000);
      check1("stall_noreq", imem_req_o, 1'b0);
    end
    stall_i = 1'b0;
    tick();
    check1("consume_vld", fd_valid_o, 1'b0);
    check1("next_req", imem_req_o, 1'b1);
    check32("next_addr", imem_addr_o, 32'h1004);

    // Redirect while waiting: response must be dropped.
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h2002;
    tick();
    redirect_i = 1'b0;
    check1("drop_noreq", imem_req_o, 1'b0);
    respond(32'hDEAD_BEEF, 1'b0, 32'h0);
    check1("drop_vld", fd_valid_o, 1'b0);
    check32("drop_instr", instruction_o, 32'h13);
    check32("redir_addr", imem_addr_o, 32'h2000);
    check1("redir_req", imem_req_o, 1'b1);

    // Redirect coincident with rvalid.
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h3000;
    respond(32'h0000_BAD1, 1'b0, 32'h0);
    redirect_i = 1'b0;
    check1("rv_redir_vld", fd_valid_o, 1'b0);
    check32("rv_redir_instr", instruction_o, 32'h13);
    check1("rv_redir_req", imem_req_o, 1'b1);
    check32("rv_redir_addr", imem_addr_o, 32'h3000);

    // Redirect coincident with request acceptance.
    imem_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h4000;
    tick();
    imem_ready_i = 1'b0; redirect_i = 1'b0;
    check1("acc_redir_noreq", imem_req_o, 1'b0);
    tick();
    respond(32'h0000_BAD2, 1'b0, 32'h0);
    check1("acc_redir_vld", fd_valid_o, 1'b0);
    check32("acc_redir_instr", instruction_o, 32'h13);

    fetch_one("d1", 32'h0050_0093, 32'h4000);
    // Squash the held instruction despite stall; misaligned target is word-aligned.
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    stall_i = 1'b0; redirect_i = 1'b0;
    check1("squash_vld", fd_valid_o, 1'b0);

    fetch_one("wrap", 32'h1111_1111, 32'hFFFF_FFFC);
    tick();
    check32("wrap_next_addr", imem_addr_o, 32'h0);

    // Asynchronous reset in the middle of WAIT.
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    #2;
    reset_i = 1'b0;
    #1;
    check1("async_vld", fd_valid_o, 1'b0);
    check32("async_instr", instruction_o, 32'h0);
    check32("async_pc", pc_o, 32'h0);
    check32("async_pcsrc", pcsrc_o, 32'h0);
    check1("async_req", imem_req_o, 1'b0);
    tick();
    reset_i = 1'b1;
    respond(32'h0000_BAD3, 1'b0, 32'h0);
    check1("stale_vld", fd_valid_o, 1'b0);
    check1("post_rst_req", imem_req_o, 1'b1);
    check32("post_rst_addr", imem_addr_o, 32'h1000);

    fetch_one("d2", 32'h2222_2222, 32'h1000);
    tick();
`ifdef FETCH_PERF_CNT_EN
    check32("cnt_one", fetch_count_o, 32'd1);
`endif
    fetch_one("d3", 32'h3333_3333, 32'h1004);
    tick();
    fetch_one("d4", 32'h4444_4444, 32'h1008);
    redirect_i = 1'b1; redirect_pc_i = 32'h5000;
    tick();
    redirect_i = 1'b0;
    fetch_one("d5", 32'h5555_5555, 32'h5000);
    tick();
    check32("final_addr", imem_addr_o, 32'h5004);
`ifdef FETCH_PERF_CNT_EN
    check32("cnt_three", fetch_count_o, 32'd3);
`endif
    check32("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: the producer side of the IF/ID pipeline register.
- Owns the PC and issues word requests to instruction memory over a req/ready + rvalid handshake.
- Presents instruction, PC and sequential next PC (pcsrc) to the fetch/decode register with a valid flag.
- Honours decode back-pressure (stall) and branch/jump redirects, and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk_i  input  1  clock, all state on rising edge
reset_i  input  1  asynchronous, active-low reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch byte address, word aligned
imem_ready_i  input  1  memory accepts request this cycle (req && ready)
imem_rvalid_i  input  1  response valid; in order, at least 1 cycle after acceptance
imem_rdata_i  input  32  response instruction word
stall_i  input  1  decode not accepting; hold outputs
redirect_i  input  1  control-flow redirect, single-cycle pulse
redirect_pc_i  input  32  redirect target
instruction_o  output  32  fetched instruction to IF/ID
pc_o  output  32  PC of instruction_o
pcsrc_o  output  32  pc_o + PC_STEP
fd_valid_o  output  1  instruction_o/pc_o/pcsrc_o valid
fetch_count_o  output  32  delivered-instruction count; present only with FETCH_PERF_CNT_EN

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset_i=0): immediate, no clock needed.
  - State REQ; pc_q=RESET_PC.
  - imem_req_o=0; instruction_o, pc_o, pcsrc_o = 0; fd_valid_o=0.
- States: REQ, WAIT, HOLD, DROP. At most one request outstanding.
- imem_req_o=1 only in REQ, and not in the first cycle after reset release. imem_addr_o=pc_q.
- REQ: on imem_ready_i go WAIT. Address stays stable while req is high and not accepted; redirect is the only exception.
- WAIT: on imem_rvalid_i, registered next edge:
  - instruction_o=imem_rdata_i; pc_o=pc_q; pcsrc_o=pc_q+PC_STEP (mod 2^32); fd_valid_o=1.
  - pc_q+=PC_STEP; go HOLD.
- HOLD: outputs stable while stall_i=1. When stall_i=0 the instruction is consumed that edge: fd_valid_o=0, go REQ.
- Latency: request issue to fd_valid_o = memory latency + 1 cycle. Peak throughput 1 instruction / 3 cycles.
- Redirect (highest priority, any state): pc_q=redirect_pc_i with [1:0] forced to 0; fd_valid_o=0. Next state by current state:
  - REQ without ready: go REQ; the next request uses the new PC.
  - REQ with imem_ready_i the same cycle: the request was accepted, go DROP.
  - WAIT without rvalid: go DROP.
  - WAIT with rvalid the same cycle: response discarded, go REQ.
  - HOLD: held instruction squashed regardless of stall_i, go REQ.
  - DROP: stays DROP; a response in that cycle is discarded and the state then goes REQ.
- DROP: discard the next imem_rvalid_i; outputs untouched, fd_valid_o stays 0; then go REQ.
- imem_rvalid_i in REQ/HOLD (protocol violation): ignored.
- stall_i has no effect when fd_valid_o=0.
- PC wrap: 0xFFFF_FFFC + 4 = 0x0000_0000. No error is raised.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - fetch_count_o port exists; reset 0.
  - Increments by 1 on each consume (fd_valid_o && !stall_i && !redirect_i); wraps at 2^32.
  - Squashed instructions are not counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- RESET_PC=0x1000, release reset, ready=1, rvalid 2 cycles later with 0x00000013 -> fd_valid_o=1, instruction_o=0x13, pc_o=0x1000, pcsrc_o=0x1004; next imem_addr_o=0x1004.
- stall_i=1 for 5 cycles while fd_valid_o=1 -> outputs constant, imem_req_o=0; on release, one cycle later req to 0x1004.
- Redirect to 0x2002 while in WAIT, then rvalid with 0xDEADBEEF -> 0xDEADBEEF never on outputs, fd_valid_o stays 0; next req addr 0x2000.
- Redirect same cycle as rvalid, and same cycle as req&&ready -> response dropped in both cases; no stale output; next req at redirect target.
- Assert reset_i=0 mid-WAIT between edges -> outputs 0 and fd_valid_o=0 immediately; after release, req at RESET_PC; a stale rvalid arriving in REQ is ignored.
- With FETCH_PERF_CNT_EN: deliver 3 instructions and squash 1 in HOLD via redirect -> fetch_count_o=3.
